spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 12 +
 rtl/spi_slave.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI bus pins between an external master and spi_slave.
// MISO_oe_o is the pad-driver enable that goes with MISO_o.
interface spi_slave_if;
    logic SCLK_i;
    logic CS_i;
    logic MOSI_i;
    logic MISO_o;
    logic MISO_oe_o;

    modport master (output SCLK_i, CS_i, MOSI_i, input MISO_o, MISO_oe_o);
    modport slave (input SCLK_i, CS_i, MOSI_i, output MISO_o, MISO_oe_o);
endinterface

// File: rtl/spi_slave.sv
// SPI slave that oversamples the bus on GCLK: all four modes, 4/8/16/32-bit words,
// back-to-back words within one CS, and frame error on a mid-word CS release.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2  // 2 or 3
) (
    input  logic        GCLK,
    input  logic        RST,
    spi_slave_if.slave  spi,
    input  logic [1:0]  spi_mode_i,
    input  logic [1:0]  word_len_i,
    input  logic [31:0] tx_data_i,
    output logic        tx_load_o,
    output logic [31:0] rx_data_o,
    output logic        rx_valid_o,
    output logic        busy_o,
    output logic        frame_err_o
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic sclk_prev_q, cs_prev_q, started_q, cs_armed_q;
    logic sclk_s, cs_s, mosi_s;
    logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;

    state_e      state_q;
    logic        cpol_q, cpha_q, skip_q;
    logic [1:0]  len_q;
    logic [4:0]  bit_cnt_q, end_idx;
    logic [31:0] shift_q, rx_buff_q, rx_data_q, rx_merged, rx_mask;
    logic        rx_valid_q, tx_load_q, busy_q, frame_err_q, miso_q;
    logic        word_done;

    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            started_q   <= 1'b0;
            cs_armed_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.CS_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            started_q   <= 1'b1;
            // CS must be seen high after reset before a fall may open a frame
            if (started_q && cs_sync_q[0]) cs_armed_q <= 1'b1;
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign lead_edge   = cpol_q ? (sclk_prev_q & ~sclk_s) : (~sclk_prev_q & sclk_s);
    assign trail_edge  = cpol_q ? (~sclk_prev_q & sclk_s) : (sclk_prev_q & ~sclk_s);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign cs_fall     = cs_armed_q & cs_prev_q & ~cs_s;
    assign cs_rise     = ~cs_prev_q & cs_s;

    always_comb begin
        unique case (len_q)
            2'd0: end_idx = 5'd0;
            2'd1: end_idx = 5'd16;
            2'd2: end_idx = 5'd24;
            2'd3: end_idx = 5'd28;
        endcase
        rx_merged            = rx_buff_q;
        rx_merged[bit_cnt_q] = mosi_s;
        rx_mask              = ~((32'd1 << end_idx) - 32'd1);
        word_done            = (bit_cnt_q == end_idx);
    end

    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            len_q       <= 2'd0;
            skip_q      <= 1'b0;
            bit_cnt_q   <= 5'd31;
            shift_q     <= '0;
            rx_buff_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            tx_load_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_q   <= StActive;
                        cpol_q    <= spi_mode_i[1];
                        cpha_q    <= spi_mode_i[0];
                        len_q     <= word_len_i;
                        // CPHA=1 spends its first leading edge re-presenting bit 31
                        skip_q    <= spi_mode_i[0];
                        bit_cnt_q <= 5'd31;
                        shift_q   <= tx_data_i;
                        tx_load_q <= 1'b1;
                        busy_q    <= 1'b1;
                        miso_q    <= tx_data_i[31];
                        rx_buff_q <= '0;
                    end
                end
                StActive: begin
                    if (cs_rise) begin
                        state_q     <= StIdle;
                        frame_err_q <= (bit_cnt_q != 5'd31);
                        busy_q      <= 1'b0;
                        miso_q      <= 1'b0;
                        rx_buff_q   <= '0;
                        bit_cnt_q   <= 5'd31;
                    end else if (sample_edge) begin
                        if (word_done) begin
                            rx_data_q  <= rx_merged & rx_mask;
                            rx_valid_q <= 1'b1;
                            rx_buff_q  <= '0;
                            bit_cnt_q  <= 5'd31;
                            shift_q    <= tx_data_i;
                            tx_load_q  <= 1'b1;
                            skip_q     <= 1'b1;
                        end else begin
                            rx_buff_q <= rx_merged;
                            bit_cnt_q <= bit_cnt_q - 5'd1;
                        end
                    end else if (shift_edge) begin
                        // shift_q[31] always mirrors the bit currently on MISO
                        if (skip_q) begin
                            miso_q <= shift_q[31];
                            skip_q <= 1'b0;
                        end else begin
                            miso_q  <= shift_q[30];
                            shift_q <= {shift_q[30:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

    assign spi.MISO_o    = miso_q;
    assign spi.MISO_oe_o = busy_q;
    assign tx_load_o     = tx_load_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign busy_o        = busy_q;
    assign frame_err_o   = frame_err_q;

endmodule
